// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline hazard controller: load-use, MUL/DIV scoreboard, memory wait and FENCE drain.
// Zero latency (controls combinational on inputs + registered state); memwait freezes EX/MEM/WB.
module hazard_scoreboard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_valid_id,
  input  logic             rs2_valid_id,
  input  logic [4:0]       rd_id,
  input  logic             rd_valid_id,
  input  logic             is_muldiv_id,
  input  logic             is_fence_id,
  input  logic [4:0]       rd_ex,
  input  logic             write_enable_ex,
  input  logic             is_load_ex,
  input  logic             is_branch_taken,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  input  logic             muldiv_done,
  input  logic [4:0]       muldiv_rd,
  output logic [1:0]       mux_if_pm,
  output logic [1:0]       mux_id_pm,
  output logic             freeze_mem,
  output logic             do_stall,
  output logic             muldiv_issue,
  output logic             muldiv_busy,
  output logic [31:0]      pending_mask,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        memwait, loaduse, raw, waw, struct_haz, fence_wait, hazard;
  logic        rs1_clr, rs2_clr, rd_clr, unit_wait;
  logic [31:0] set_mask, clr_mask, pending_nxt;

  assign memwait    = dmem_req_mem & ~dmem_ready;
  assign rs1_clr    = muldiv_done & (muldiv_rd == rs1_id);
  assign rs2_clr    = muldiv_done & (muldiv_rd == rs2_id);
  assign rd_clr     = muldiv_done & (muldiv_rd == rd_id);
  assign unit_wait  = muldiv_busy & ~muldiv_done;

  assign loaduse    = is_load_ex & write_enable_ex & (rd_ex != 5'd0) &
                      ((rs1_valid_id & (rs1_id == rd_ex)) | (rs2_valid_id & (rs2_id == rd_ex)));
  assign raw        = (rs1_valid_id & pending_mask[rs1_id] & ~rs1_clr) |
                      (rs2_valid_id & pending_mask[rs2_id] & ~rs2_clr);
  assign waw        = rd_valid_id & pending_mask[rd_id] & ~rd_clr;
  assign struct_haz = is_muldiv_id & unit_wait;
  assign fence_wait = is_fence_id & unit_wait;
  assign hazard     = loaduse | raw | waw | struct_haz | fence_wait | (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN also exits once the unit is idle, so a completion hidden under memwait cannot strand it.
  always_comb begin
    state_nxt = state;
    if (!memwait) begin
      case (state)
        RUN:     if (!is_branch_taken && fence_wait) state_nxt = DRAIN;
        DRAIN:   if (is_branch_taken || muldiv_done || !muldiv_busy) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    mux_if_pm    = 2'b00;
    mux_id_pm    = 2'b00;
    freeze_mem   = 1'b0;
    do_stall     = 1'b0;
    muldiv_issue = 1'b0;
    if (!rst_n) begin
      mux_if_pm = 2'b01;
      mux_id_pm = 2'b01;
    end else if (memwait) begin
      mux_if_pm  = 2'b10;
      mux_id_pm  = 2'b10;
      freeze_mem = 1'b1;
    end else if (is_branch_taken) begin
      mux_if_pm = 2'b01;
      mux_id_pm = 2'b01;
    end else if (hazard) begin
      mux_if_pm = 2'b10;
      mux_id_pm = 2'b01;
      do_stall  = 1'b1;
    end else begin
      muldiv_issue = is_muldiv_id & rd_valid_id;
    end
  end

  // A new issue to the same register overrides a completion clearing it.
  assign set_mask    = (muldiv_issue && rd_id != 5'd0) ? (32'd1 << rd_id) : 32'd0;
  assign clr_mask    = muldiv_done ? (32'd1 << muldiv_rd) : 32'd0;
  assign pending_nxt = ((pending_mask & ~clr_mask) | set_mask) & ~32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_mask <= 32'd0;
      muldiv_busy  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      pending_mask <= pending_nxt;
      muldiv_busy  <= muldiv_issue | unit_wait;
      if (mux_if_pm == 2'b10 && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl; ctl packs {mux_if, mux_id, freeze_mem, do_stall, muldiv_issue}.
module tb_hazard_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_id, rs2_id, rd_id, rd_ex, muldiv_rd;
  logic        rs1_valid_id, rs2_valid_id, rd_valid_id, is_muldiv_id, is_fence_id;
  logic        write_enable_ex, is_load_ex, is_branch_taken, dmem_req_mem, dmem_ready, muldiv_done;
  logic [1:0]  mux_if_pm, mux_id_pm;
  logic        freeze_mem, do_stall, muldiv_issue, muldiv_busy;
  logic [31:0] pending_mask;
  logic [31:0] stall_cycles;
  logic [6:0]  ctl;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_stall = 0;

  localparam logic [6:0] NORM  = 7'b00_00_0_0_0;
  localparam logic [6:0] ISSUE = 7'b00_00_0_0_1;
  localparam logic [6:0] HAZ   = 7'b10_01_0_1_0;
  localparam logic [6:0] MEMW  = 7'b10_10_1_0_0;
  localparam logic [6:0] FLUSH = 7'b01_01_0_0_0;

  assign ctl = {mux_if_pm, mux_id_pm, freeze_mem, do_stall, muldiv_issue};

  hazard_scoreboard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_valid_id(rs1_valid_id), .rs2_valid_id(rs2_valid_id),
    .rd_id(rd_id), .rd_valid_id(rd_valid_id), .is_muldiv_id(is_muldiv_id), .is_fence_id(is_fence_id),
    .rd_ex(rd_ex), .write_enable_ex(write_enable_ex), .is_load_ex(is_load_ex),
    .is_branch_taken(is_branch_taken), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .muldiv_done(muldiv_done), .muldiv_rd(muldiv_rd),
    .mux_if_pm(mux_if_pm), .mux_id_pm(mux_id_pm), .freeze_mem(freeze_mem), .do_stall(do_stall),
    .muldiv_issue(muldiv_issue), .muldiv_busy(muldiv_busy), .pending_mask(pending_mask),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_id = 5'd0; rd_ex = 5'd0; muldiv_rd = 5'd0;
    rs1_valid_id = 1'b0; rs2_valid_id = 1'b0; rd_valid_id = 1'b0;
    is_muldiv_id = 1'b0; is_fence_id = 1'b0; write_enable_ex = 1'b0; is_load_ex = 1'b0;
    is_branch_taken = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0; muldiv_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    n_cmp++; if (ctl !== FLUSH) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, FLUSH); end
    n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL reset_pending: got %h want 0", pending_mask); end
    n_cmp++; if (muldiv_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", muldiv_busy); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cycles); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (ctl !== NORM) begin n_bad++; $display("FAIL reset_release: got %b want %b", ctl, NORM); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    is_load_ex = 1'b1; write_enable_ex = 1'b1; rd_ex = 5'd5; rs1_valid_id = 1'b1; rs1_id = 5'd5;
    #1;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL loaduse_rs1: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    idle(); rs1_valid_id = 1'b1; rs1_id = 5'd5;
    #1;
    n_cmp++; if (ctl !== NORM) begin n_bad++; $display("FAIL loaduse_moved_on: got %b want %b", ctl, NORM); end
    is_load_ex = 1'b1; write_enable_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
    #1;
    n_cmp++; if (ctl !== NORM) begin n_bad++; $display("FAIL loaduse_x0: got %b want %b", ctl, NORM); end
    tick();
    idle(); is_load_ex = 1'b1; write_enable_ex = 1'b1; rd_ex = 5'd6; rs2_valid_id = 1'b1; rs2_id = 5'd6;
    rs1_id = 5'd6;
    #1;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL loaduse_rs2: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    idle(); is_load_ex = 1'b1; write_enable_ex = 1'b1; rd_ex = 5'd6; rs1_id = 5'd6;
    #1;
    n_cmp++; if (ctl !== NORM) begin n_bad++; $display("FAIL loaduse_rs1_not_read: got %b want %b", ctl, NORM); end
    tick();
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL loaduse_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_raw_bypass();
    idle(); is_muldiv_id = 1'b1; rd_valid_id = 1'b1; rd_id = 5'd7;
    #1;
    n_cmp++; if (ctl !== ISSUE) begin n_bad++; $display("FAIL mul_issue: got %b want %b", ctl, ISSUE); end
    tick();
    n_cmp++; if (pending_mask !== 32'h80) begin n_bad++; $display("FAIL mul_pending: got %h want 00000080", pending_mask); end
    n_cmp++; if (muldiv_busy !== 1'b1) begin n_bad++; $display("FAIL mul_busy: got %b want 1", muldiv_busy); end
    idle(); rs1_valid_id = 1'b1; rs1_id = 5'd7; rs2_valid_id = 1'b1; rs2_id = 5'd1;
    rd_valid_id = 1'b1; rd_id = 5'd8;
    #1;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL raw_stall1: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL raw_stall2: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    muldiv_done = 1'b1; muldiv_rd = 5'd7;
    #1;
    n_cmp++; if (ctl !== NORM) begin n_bad++; $display("FAIL raw_bypass: got %b want %b", ctl, NORM); end
    tick();
    n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL raw_cleared: got %h want 0", pending_mask); end
    n_cmp++; if (muldiv_busy !== 1'b0) begin n_bad++; $display("FAIL raw_idle: got %b want 0", muldiv_busy); end
  endtask

  task automatic test_back_to_back();
    idle(); is_muldiv_id = 1'b1; rd_valid_id = 1'b1; rd_id = 5'd3;
    tick();
    idle(); rd_valid_id = 1'b1; rd_id = 5'd3;
    #1;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL waw_stall: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    idle(); is_muldiv_id = 1'b1; rd_valid_id = 1'b1; rd_id = 5'd9; rs1_valid_id = 1'b1; rs1_id = 5'd1;
    #1;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL struct_stall: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    muldiv_done = 1'b1; muldiv_rd = 5'd3;
    #1;
    n_cmp++; if (ctl !== ISSUE) begin n_bad++; $display("FAIL issue_on_done: got %b want %b", ctl, ISSUE); end
    tick();
    n_cmp++; if (muldiv_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", muldiv_busy); end
    n_cmp++; if (pending_mask !== 32'h200) begin n_bad++; $display("FAIL b2b_pending: got %h want 00000200", pending_mask); end
    idle(); muldiv_done = 1'b1; muldiv_rd = 5'd9;
    tick();
    n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL b2b_cleared: got %h want 0", pending_mask); end
    idle(); is_muldiv_id = 1'b1; rd_valid_id = 1'b1; rd_id = 5'd0;
    #1;
    n_cmp++; if (ctl !== ISSUE) begin n_bad++; $display("FAIL x0_issue: got %b want %b", ctl, ISSUE); end
    tick();
    n_cmp++; if (muldiv_busy !== 1'b1 || pending_mask !== 32'd0) begin
      n_bad++; $display("FAIL x0_state: got busy=%b mask=%h want busy=1 mask=0", muldiv_busy, pending_mask);
    end
    idle(); muldiv_done = 1'b1;
    tick();
    n_cmp++; if (muldiv_busy !== 1'b0) begin n_bad++; $display("FAIL x0_done: got %b want 0", muldiv_busy); end
  endtask

  task automatic test_fence();
    idle(); is_muldiv_id = 1'b1; rd_valid_id = 1'b1; rd_id = 5'd4;
    tick();
    idle(); is_fence_id = 1'b1;
    #1;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL fence_wait: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL fence_drain: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    muldiv_done = 1'b1; muldiv_rd = 5'd4;
    #1;
    n_cmp++; if (ctl !== HAZ) begin n_bad++; $display("FAIL fence_drain_on_done: got %b want %b", ctl, HAZ); end
    tick(); exp_stall++;
    muldiv_done = 1'b0;
    #1;
    n_cmp++; if (ctl !== NORM) begin n_bad++; $display("FAIL fence_advance: got %b want %b", ctl, NORM); end
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL fence_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
    tick();
  endtask

  task automatic test_memwait_branch();
    idle(); dmem_req_mem = 1'b1; dmem_ready = 1'b0; is_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ctl !== MEMW) begin n_bad++; $display("FAIL memwait_cycle%0d: got %b want %b", i, ctl, MEMW); end
      tick(); exp_stall++;
    end
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL memwait_stall_cnt: got %0d want %0d", stall_cycles, exp_stall); end
    dmem_ready = 1'b1;
    #1;
    n_cmp++; if (ctl !== FLUSH) begin n_bad++; $display("FAIL branch_after_wait: got %b want %b", ctl, FLUSH); end
    tick();
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL flush_no_count: got %0d want %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_reset_mid_drain();
    idle(); is_muldiv_id = 1'b1; rd_valid_id = 1'b1; rd_id = 5'd5;
    tick();
    n_cmp++; if (pending_mask !== 32'h20) begin n_bad++; $display("FAIL drain_pending: got %h want 00000020", pending_mask); end
    idle(); is_fence_id = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ctl !== FLUSH) begin n_bad++; $display("FAIL reset_forced: got %b want %b", ctl, FLUSH); end
    tick();
    n_cmp++; if (pending_mask !== 32'd0 || muldiv_busy !== 1'b0 || stall_cycles !== 32'd0) begin
      n_bad++; $display("FAIL reset_mid_drain: got mask=%h busy=%b cnt=%0d want 0/0/0", pending_mask, muldiv_busy, stall_cycles);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (ctl !== NORM) begin n_bad++; $display("FAIL run_after_reset: got %b want %b", ctl, NORM); end
    idle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_raw_bypass();
    test_back_to_back();
    test_fence();
    test_memwait_branch();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
